// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/compare/shift ops plus
// iterative unsigned multiply, divide and remainder behind valid/ready.
module iter_alu #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SHAMT_W-1:0] cnt_q;
  logic               is_rem_q;
  logic [WIDTH-1:0]   a_q, b_q, acc_q;

  logic               accept, last, div_zero;
  logic               wr_en;
  logic [WIDTH-1:0]   wr_val;
  logic [WIDTH-1:0]   alu_res, imm16;
  logic [SHAMT_W-1:0] sra_amt, srav_amt;
  logic [WIDTH-1:0]   mul_acc, rem_nx, q_nx;
  logic [WIDTH:0]     rem_sh, diff;

  assign ready_o  = state_q == S_IDLE;
  assign valid_o  = state_q == S_DONE;
  assign accept   = valid_i && ready_o;
  assign last     = cnt_q == SHAMT_W'(WIDTH - 1);
  assign div_zero = b_q == '0;

  // SRA takes its amount from the shamt field src1[10:6]
  assign sra_amt  = SHAMT_W'((src1_i >> 6) & WIDTH'(31));
  assign srav_amt = src1_i[SHAMT_W-1:0];
  assign imm16    = src2_i & WIDTH'(32'h0000_FFFF);

  always_comb begin
    alu_res = '0;
    case (ctrl_i)
      4'd0:  alu_res = src1_i & src2_i;
      4'd1:  alu_res = src1_i | src2_i;
      4'd2:  alu_res = src1_i + src2_i;
      4'd3:  alu_res = WIDTH'(src1_i < imm16);
      4'd4:  alu_res = WIDTH'($signed(src1_i) < $signed(src2_i));
      4'd5:  alu_res = WIDTH'(src1_i < src2_i);
      4'd6:  alu_res = src1_i - src2_i;
      4'd7:  alu_res = WIDTH'(src1_i != src2_i);
      4'd8:  alu_res = $signed(src2_i) >>> sra_amt;
      4'd9:  alu_res = $signed(src2_i) >>> srav_amt;
      4'd10: alu_res = WIDTH'(src1_i == src2_i);
      4'd11: alu_res = src2_i << (WIDTH / 2);
      4'd12, 4'd13, 4'd14: alu_res = '0;
      4'd15: alu_res = ~(src1_i | src2_i);
      default: alu_res = '0;
    endcase
  end

  // one shift-add step and one restoring-division step
  assign mul_acc = acc_q + (b_q[0] ? a_q : '0);
  assign rem_sh  = {acc_q, a_q[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, b_q};
  assign rem_nx  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_nx    = {a_q[WIDTH-2:0], ~diff[WIDTH]};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_val  = alu_res;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            ctrl_i == 4'd12: state_d = S_MUL;
            ctrl_i == 4'd13,
            ctrl_i == 4'd14: state_d = S_DIV;
            default: begin
              state_d = S_DONE;
              wr_en   = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        if (last) begin
          state_d = S_DONE;
          wr_en   = 1'b1;
          wr_val  = mul_acc;
        end
      end
      S_DIV: begin
        if (div_zero) begin
          state_d = S_DONE;
          wr_en   = 1'b1;
          wr_val  = is_rem_q ? a_q : '1;
        end else if (last) begin
          state_d = S_DONE;
          wr_en   = 1'b1;
          wr_val  = is_rem_q ? rem_nx : q_nx;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_o <= '0;
      zero_o   <= 1'b1;
    end else begin
      if (wr_en) begin
        result_o <= wr_val;
        zero_o   <= wr_val == '0;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q      <= src1_i;
            b_q      <= src2_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            is_rem_q <= ctrl_i == 4'd14;
          end
        end
        S_MUL: begin
          acc_q <= mul_acc;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
        end
        S_DIV: begin
          acc_q <= rem_nx;
          a_q   <= q_nx;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Randomised bench for iter_alu against an arithmetic reference model.
// A scoreboard queue holds expected result and due cycle per accepted op.
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [3:0]  ctrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic        zero_o;

  iter_alu #(.WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ctrl_i   (ctrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .zero_o   (zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic [3:0]  op;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want,
               $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return 32'(a < {16'h0, b[15:0]});
      4'd4:  return 32'($signed(a) < $signed(b));
      4'd5:  return 32'(a < b);
      4'd6:  return a - b;
      4'd7:  return 32'(a != b);
      4'd8:  return 32'($signed(b) >>> a[10:6]);
      4'd9:  return 32'($signed(b) >>> a[4:0]);
      4'd10: return 32'(a == b);
      4'd11: return b << 16;
      4'd12: begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: return (b == 0) ? a : a % b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic int lat(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'd12) return 33;
    if (op == 4'd13 || op == 4'd14) return (b == 0) ? 2 : 33;
    return 1;
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      3: return 32'h8000_0000 | 32'($urandom);
      default: return 32'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_i) begin
      chk("ready", 32'(ready_o), 32'(q.size() == 0));
      if (valid_o) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(valid_o), 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("latency op%0d", e.op), 32'(cyc), 32'(e.due));
          chk($sformatf("result op%0d", e.op), result_o, e.res);
          chk($sformatf("zero op%0d", e.op), 32'(zero_o),
              32'(e.res == 0));
        end
      end else if (q.size() != 0 && cyc >= q[0].due) begin
        chk($sformatf("missing_valid op%0d", q[0].op), 32'(valid_o), 32'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit pin,
                       input logic [31:0] want);
    int          w;
    exp_t        e;
    logic [31:0] m;
    w = 0;
    @(negedge clk);
    while (!ready_o && w < 100) begin
      valid_i = 1'($urandom);
      ctrl_i  = 4'($urandom);
      src1_i  = $urandom;
      src2_i  = $urandom;
      w++;
      @(negedge clk);
    end
    if (!ready_o) begin
      chk("ready_timeout", 32'(ready_o), 32'd1);
      valid_i = 1'b0;
      return;
    end
    valid_i = 1'b1;
    ctrl_i  = op;
    src1_i  = a;
    src2_i  = b;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    ctrl_i  = 4'($urandom);
    src1_i  = $urandom;
    src2_i  = $urandom;
    m = model(op, a, b);
    if (pin) chk($sformatf("model_pin op%0d", op), m, want);
    e.due = cyc + lat(op, b) - 1;
    e.res = pin ? want : m;
    e.op  = op;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_i = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_zero", 32'(zero_o), 32'd1);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          w;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ctrl_i  = '0;
    src1_i  = '0;
    src2_i  = '0;
    do_reset();

    issue(4'd12, 32'h0001_0000, 32'h0001_0001, 1'b1, 32'h0001_0000);
    repeat (10) @(posedge clk);
    do_reset();
    repeat (40) @(negedge clk);

    issue(4'd2,  32'hFFFF_FFFF, 32'h1,         1'b1, 32'h0);
    issue(4'd6,  32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE);
    issue(4'd4,  32'hFFFF_FFFF, 32'h1,         1'b1, 32'h1);
    issue(4'd5,  32'hFFFF_FFFF, 32'h1,         1'b1, 32'h0);
    issue(4'd3,  32'd3,         32'hFFFF_0004, 1'b1, 32'h1);
    issue(4'd9,  32'd4,         32'h8000_0000, 1'b1, 32'hF800_0000);
    issue(4'd8,  32'h0000_0100, 32'h8000_0000, 1'b1, 32'hF800_0000);
    issue(4'd11, 32'h0,         32'h0000_1234, 1'b1, 32'h1234_0000);
    issue(4'd15, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFF);
    issue(4'd10, 32'hABCD,      32'hABCD,      1'b1, 32'h1);
    issue(4'd7,  32'hABCD,      32'hABCD,      1'b1, 32'h0);
    issue(4'd12, 32'h0001_0000, 32'h0001_0001, 1'b1, 32'h0001_0000);
    issue(4'd13, 32'd100,       32'd7,         1'b1, 32'd14);
    issue(4'd14, 32'd100,       32'd7,         1'b1, 32'd2);
    issue(4'd13, 32'd12345,     32'd0,         1'b1, 32'hFFFF_FFFF);
    issue(4'd14, 32'd9,         32'd0,         1'b1, 32'd9);
    issue(4'd12, 32'd0,         32'hFFFF_FFFF, 1'b1, 32'd0);
    issue(4'd13, 32'hFFFF_FFFF, 32'd1,         1'b1, 32'hFFFF_FFFF);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom);
      a  = rnd();
      b  = rnd();
      issue(op, a, b, 1'b0, 32'd0);
    end

    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) chk("drain", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
